// File: rtl/xor_operand_loader_if.sv
// Switch/button inputs and registered operand outputs of the XOR operand loader.
// The master side is the board (switches, buttons); the slave side is the loader.
interface xor_operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             btn_load;
    logic             btn_clear;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic [1:0]       state_o;
    logic [7:0]       op_count;

    modport master (
        output sw, btn_load, btn_clear,
        input  a, b, valid, state_o, op_count
    );

    modport slave (
        input  sw, btn_load, btn_clear,
        output a, b, valid, state_o, op_count
    );
endinterface

// File: rtl/xor_operand_loader.sv
// Two-press operand entry for the 4-bit XOR unit: first load press captures a, second captures b.
// Optional button debouncing is enabled by defining XOR_LOADER_DEBOUNCE_EN.
module xor_operand_loader #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst,
    xor_operand_loader_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        READY  = 2'b10
    } state_t;

    if (DEB_CYCLES < 2) begin : g_deb_check
        $error("DEB_CYCLES must be at least 2");
    end

    // bit 0 is the load button, bit 1 the clear button
    logic [1:0] btn_raw;
    logic [1:0] btn_sync_p0;
    logic [1:0] btn_sync_p1;
    logic [1:0] btn_lvl;

    assign btn_raw = {bus.btn_clear, bus.btn_load};

    // Stage p0/p1: two-flop synchronizer on both buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
        end else begin
            btn_sync_p0 <= btn_raw;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

`ifdef XOR_LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       deb_lvl;

    // Level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb_lvl[i] <= btn_sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = deb_lvl;
`else
    assign btn_lvl = btn_sync_p1;
`endif

    logic load_prev;
    logic load_pulse;
    logic clr;

    always_ff @(posedge clk) begin
        if (rst) load_prev <= 1'b0;
        else     load_prev <= btn_lvl[0];
    end

    assign load_pulse = btn_lvl[0] & ~load_prev;
    assign clr        = btn_lvl[1];

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             valid_q;
    logic [7:0]       count_q;

    // Entry FSM; clear outranks load, and a load in the same cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else if (clr) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load_pulse) begin
                        a_q   <= bus.sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_pulse) begin
                        b_q     <= bus.sw;
                        valid_q <= 1'b1;
                        count_q <= count_q + 8'd1;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (load_pulse) begin
                        a_q     <= bus.sw;
                        b_q     <= '0;
                        valid_q <= 1'b0;
                        state   <= LOAD_B;
                    end
                end
                default: begin
                    state   <= LOAD_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.valid    = valid_q;
    assign bus.state_o  = state;
    assign bus.op_count = count_q;

endmodule

// File: tb/tb_xor_operand_loader.sv
// Directed bench for xor_operand_loader; the downstream XOR result is formed here as a ^ b.
// Timing adapts when XOR_LOADER_DEBOUNCE_EN is defined.
module tb_xor_operand_loader;

    localparam int WIDTH = 4;
    localparam int DEB   = 16;
`ifdef XOR_LOADER_DEBOUNCE_EN
    localparam int EXTRA = DEB;
    localparam int PRESS = 20;
`else
    localparam int EXTRA = 0;
    localparam int PRESS = 2;
`endif
    localparam int SETTLE = EXTRA + 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    xor_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    xor_operand_loader #(
        .WIDTH(WIDTH),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [WIDTH-1:0] v);
        bus.sw       = v;
        bus.btn_load = 1'b1;
        tick(PRESS);
        bus.btn_load = 1'b0;
        tick(SETTLE);
    endtask

    function automatic logic [WIDTH-1:0] z_of();
        return bus.a ^ bus.b;
    endfunction

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.sw        = '0;
        bus.btn_load  = 1'b0;
        bus.btn_clear = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_a", 32'(bus.a), 32'h0);
        check("rst_b", 32'(bus.b), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_state", 32'(bus.state_o), 32'h0);
        check("rst_count", 32'(bus.op_count), 32'h0);

        // first press: capture exactly 2 (+debounce) edges after the first sample
        bus.sw       = 4'h3;
        bus.btn_load = 1'b1;
        tick(1);
        check("lat_k_a", 32'(bus.a), 32'h0);
        tick(1 + EXTRA);
        check("lat_k1_a", 32'(bus.a), 32'h0);
        check("lat_k1_state", 32'(bus.state_o), 32'h0);
        tick(1);
        check("lat_k2_a", 32'(bus.a), 32'h3);
        check("lat_k2_state", 32'(bus.state_o), 32'h1);
        bus.btn_load = 1'b0;
        tick(SETTLE);

        bus.sw = 4'h9;
        tick(5);
        check("sw_noeffect_a", 32'(bus.a), 32'h3);

        press_load(4'h5);
        check("pair_a", 32'(bus.a), 32'h3);
        check("pair_b", 32'(bus.b), 32'h5);
        check("pair_valid", 32'(bus.valid), 32'h1);
        check("pair_state", 32'(bus.state_o), 32'h2);
        check("pair_count", 32'(bus.op_count), 32'h1);
        check("pair_z", 32'(z_of()), 32'h6);

        press_load(4'hF);
        check("restart_a", 32'(bus.a), 32'hF);
        check("restart_b", 32'(bus.b), 32'h0);
        check("restart_valid", 32'(bus.valid), 32'h0);
        check("restart_state", 32'(bus.state_o), 32'h1);
        press_load(4'hF);
        check("restart_z", 32'(z_of()), 32'h0);
        check("restart_count", 32'(bus.op_count), 32'h2);
        check("restart_valid2", 32'(bus.valid), 32'h1);

        // long hold from READY must capture once, ignoring sw changes while held
        bus.sw       = 4'h9;
        bus.btn_load = 1'b1;
        tick(50);
        bus.sw = 4'h4;
        tick(10);
        bus.btn_load = 1'b0;
        tick(SETTLE);
        check("hold_state", 32'(bus.state_o), 32'h1);
        check("hold_a", 32'(bus.a), 32'h9);
        check("hold_b", 32'(bus.b), 32'h0);
        check("hold_count", 32'(bus.op_count), 32'h2);

        // clear and load together in LOAD_B
        bus.sw        = 4'h7;
        bus.btn_load  = 1'b1;
        bus.btn_clear = 1'b1;
        tick(PRESS);
        bus.btn_load  = 1'b0;
        bus.btn_clear = 1'b0;
        tick(SETTLE);
        check("clr_state", 32'(bus.state_o), 32'h0);
        check("clr_a", 32'(bus.a), 32'h0);
        check("clr_b", 32'(bus.b), 32'h0);
        check("clr_valid", 32'(bus.valid), 32'h0);
        check("clr_count", 32'(bus.op_count), 32'h2);

        // 254 more pairs take the count from 2 through 255 back to 0
        for (int i = 0; i < 254; i++) begin
            press_load(4'(i));
            press_load(4'(~i));
        end
        check("wrap_count", 32'(bus.op_count), 32'h0);
        check("wrap_state", 32'(bus.state_o), 32'h2);
        press_load(4'hC);
        press_load(4'h3);
        check("wrap_count1", 32'(bus.op_count), 32'h1);
        check("wrap_z", 32'(z_of()), 32'hF);

        // reset mid-entry discards the partial pair
        press_load(4'hA);
        check("mid_state", 32'(bus.state_o), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_state", 32'(bus.state_o), 32'h0);
        check("mid_rst_a", 32'(bus.a), 32'h0);
        check("mid_rst_count", 32'(bus.op_count), 32'h0);

`ifdef XOR_LOADER_DEBOUNCE_EN
        bus.sw       = 4'h6;
        bus.btn_load = 1'b1;
        tick(10);
        bus.btn_load = 1'b0;
        tick(SETTLE);
        check("glitch_state", 32'(bus.state_o), 32'h0);
        check("glitch_a", 32'(bus.a), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_operand_loader.md
# xor_operand_loader

Sequential operand-entry stage placed directly upstream of the 4-bit XOR unit. It captures two operands from the board switches with a single load push-button (first press to `a`, second press to `b`), holds them stable on its outputs, and flags when the pair is complete. Its `a`/`b` outputs wire straight into the XOR unit's `a`/`b` inputs, and `valid` qualifies the XOR result `z` for the display stage.

## Interface
- `WIDTH`, 4: operand width; it must match the XOR unit.
- `DEB_CYCLES`, 16: number of stable cycles required by the debouncer. It is only used when `DEBOUNCE_EN` is defined, and the minimum value is 2.

- `clk`  in  1  the single system clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  WIDTH  switch value. It is sampled on the capture edge.
- `btn_load`  in  1  asynchronous push-button that loads the next operand.
- `btn_clear`  in  1  asynchronous push-button that aborts entry and zeroes the operands.
- `a`  out  WIDTH  registered operand A, sent to the XOR unit.
- `b`  out  WIDTH  registered operand B, sent to the XOR unit.
- `valid`  out  1  high while both operands are loaded (state READY).
- `state_o`  out  2  current FSM state, used for LEDs: 00 LOAD_A, 01 LOAD_B, 10 READY.
- `op_count`  out  8  number of completed operand pairs.

## Operation
- **Input conditioning**
  - `btn_load` and `btn_clear` each pass through a 2-flop synchronizer.
  - `load_pulse` is high for exactly one cycle on each rising edge of the conditioned load level. It uses a registered previous level.
  - The conditioned clear level (`clr`) is level-sensitive.
- **FSM states:** LOAD_A, LOAD_B, READY. Encoding 11 is unreachable; if it is ever entered, the FSM goes to LOAD_A on the next edge.
- **Priority:** `rst` > `clr` > `load_pulse`.
- **`clr` high:** from any state, go to LOAD_A with `a`=0, `b`=0, `valid`=0. `op_count` is unchanged. A `load_pulse` in the same cycle is dropped.
- **LOAD_A + `load_pulse`:** `a` <= `sw`, go to LOAD_B.
- **LOAD_B + `load_pulse`:** `b` <= `sw`, `valid` <= 1, `op_count` <= `op_count`+1 (mod 256, wraps 255 to 0), go to READY.
- **READY + `load_pulse`:** starts a new pair.
  - `a` <= `sw`, `b` <= 0, `valid` <= 0, go to LOAD_B.
- **No pulse:** all registers hold their values. `sw` changes have no effect outside a capture edge.
- **Button held:** a button held high for many cycles produces exactly one capture.

## Timing
- **Reset values:** on `rst` high at an edge:
  - state LOAD_A, `a`=0, `b`=0, `valid`=0, `op_count`=0, `state_o`=00;
  - synchronizer, edge-detect and debounce registers cleared.
- **Reset mid-entry:** `rst` during LOAD_B or READY discards the partial or complete pair.
- **Load latency, without `DEBOUNCE_EN`:**
  - `btn_load` is first sampled high at edge k.
  - Capture happens at edge k+2, and outputs change after edge k+2.
  - A press must be at least 1 cycle high to be seen.
- **Clear latency:** `clr` is seen at edge k+1, and outputs clear at edge k+2.
- **Outputs:** `a`, `b`, `valid`, `state_o` and `op_count` are all registered. They change only on `clk` rising edges, and there are no combinational paths from inputs to outputs.
- **Downstream result:** the XOR unit's `z` (combinational) is valid in the same cycle that `valid` is high.

## Configuration
- **Macro:** `XOR_LOADER_DEBOUNCE_EN`.
- **Defined:** each synchronized button feeds a debouncer built from a counter of width clog2(DEB_CYCLES)+1.
  - The debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
  - Any bounce back to the current level resets the counter.
  - Load and clear latency increase by DEB_CYCLES edges.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
- **Undefined:** there is no debouncer; the synchronized level is used directly, with the latency given in Timing.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then release → `a`=0, `b`=0, `valid`=0, `state_o`=00, `op_count`=0.
- **Basic pair:** `sw`=3, pulse load; then `sw`=5, pulse load → `a`=3, `b`=5, `valid`=1, `state_o`=10, `op_count`=1, XOR `z`=6. Capture occurs exactly 2 edges after the first sample (macro off).
- **Restart from READY:** from READY with `sw`=0xF, pulse load → `a`=F, `b`=0, `valid`=0, `state_o`=01. Then `sw`=0xF, pulse load → `z`=0, `op_count`=2.
- **Held button and clear priority:**
  - Hold `btn_load` for 50 cycles → exactly one capture.
  - Assert clear and load together in LOAD_B → state 00, `a`=`b`=0, and the load is ignored.
- **Wrap-around:** complete 256 pairs → `op_count` returns to 0, and the 257th pair gives 1.
- **Debounce (macro on, `DEB_CYCLES`=16):**
  - A 10-cycle glitch on `btn_load` → no capture.
  - A 20-cycle press → one capture at edge k+2+16.
